// File: rtl/nand_avalon_host.sv
// Command sequencer for the nand_avalon register port: optional data write, command write,
// status polling with timeout, optional data read, then a one-cycle response pulse.
module nand_avalon_host #(
  parameter int POLL_GAP  = 2,
  parameter int MAX_POLLS = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic        req_has_wdata,
  input  logic [7:0]  req_wdata,
  input  logic        req_rd,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [1:0]  address,
  output logic        pwrite,
  output logic        pread,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  localparam int CW = $clog2(MAX_POLLS + 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(MAX_POLLS - 1);
  localparam logic [CW-1:0] POLL_MAX  = CW'(MAX_POLLS);
  localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_WD_STB, S_WD_HOLD, S_CMD_STB, S_CMD_HOLD, S_POLL, S_GAP, S_RD, S_RESP
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_cmd, r_wdata, r_rspData;
  logic            r_hasWdata, r_rd, r_rspErr;
  logic [CW-1:0]   r_pollCnt;
  logic [GW-1:0]   r_gapCnt;
  logic            w_accept, w_statusDone, w_timeout;
  logic            w_unusedReaddata;

  assign w_accept         = req_valid && (r_state == S_IDLE);
  assign w_statusDone     = !readdata[0] && readdata[1];
  // The poll in progress is number r_pollCnt+1, so it is the last allowed one at MAX_POLLS-1.
  assign w_timeout        = (r_pollCnt >= POLL_LAST);
  assign w_unusedReaddata = ^readdata[31:8];

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = req_has_wdata ? S_WD_STB : S_CMD_STB;
      S_WD_STB:   w_next = S_WD_HOLD;
      S_WD_HOLD:  w_next = S_CMD_STB;
      S_CMD_STB:  w_next = S_CMD_HOLD;
      S_CMD_HOLD: w_next = S_POLL;
      S_POLL: begin
        if (w_statusDone)      w_next = r_rd ? S_RD : S_RESP;
        else if (w_timeout)    w_next = S_RESP;
        else if (POLL_GAP > 0) w_next = S_GAP;
        else                   w_next = S_POLL;
      end
      S_GAP:      if (r_gapCnt == GAP_LAST) w_next = S_POLL;
      S_RD:       w_next = S_RESP;
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    address   = 2'd0;
    pwrite    = 1'b1;
    pread     = 1'b1;
    writedata = 32'd0;
    case (r_state)
      S_WD_STB, S_WD_HOLD: begin
        writedata = {24'd0, r_wdata};
        pwrite    = (r_state != S_WD_STB);
      end
      S_CMD_STB, S_CMD_HOLD: begin
        address   = 2'd1;
        writedata = {24'd0, r_cmd};
        pwrite    = (r_state != S_CMD_STB);
      end
      S_POLL: begin
        address = 2'd2;
        pread   = 1'b0;
      end
      S_RD:    pread = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd      <= 8'd0;
      r_wdata    <= 8'd0;
      r_hasWdata <= 1'b0;
      r_rd       <= 1'b0;
    end else if (w_accept) begin
      r_cmd      <= req_cmd;
      r_wdata    <= req_wdata;
      r_hasWdata <= req_has_wdata;
      r_rd       <= req_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pollCnt <= '0;
      r_gapCnt  <= '0;
    end else begin
      if (w_accept) r_pollCnt <= '0;
      else if (r_state == S_POLL && r_pollCnt != POLL_MAX) r_pollCnt <= r_pollCnt + CW'(1);
      if (r_state == S_POLL)     r_gapCnt <= '0;
      else if (r_state == S_GAP) r_gapCnt <= r_gapCnt + GW'(1);
    end
  end

  // Response fields only change on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspData <= 8'd0;
      r_rspErr  <= 1'b0;
    end else if ((r_state == S_POLL || r_state == S_RD) && w_next == S_RESP) begin
      r_rspData <= readdata[7:0];
      r_rspErr  <= (r_state == S_POLL) && !w_statusDone;
    end
  end

endmodule

// File: tb/tb_nand_avalon_host.sv
// Self-checking bench for nand_avalon_host: a register-port responder plus a per-request
// expected bus timeline built from the command's phases (writes, polls, gaps, read, response).
module tb_nand_avalon_host;

  localparam int POLL_GAP  = 2;
  localparam int MAX_POLLS = 4;

  logic        clk, rst;
  logic        req_valid, req_ready, req_has_wdata, req_rd;
  logic [7:0]  req_cmd, req_wdata;
  logic        rsp_valid, rsp_err, pwrite, pread;
  logic [7:0]  rsp_data;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;

  nand_avalon_host #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_has_wdata(req_has_wdata), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .address(address), .pwrite(pwrite), .pread(pread),
    .writedata(writedata), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pw;
    logic        pr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        rv;
    logic        rdy;
  } busT;

  int          nChecks = 0;
  int          nPass   = 0;
  int          pollCount = 0;
  int          pollBase  = 0;
  int          curBusy   = 0;
  int          tbIdx;
  logic [7:0]  curBusyStat = 8'h01;
  logic [7:0]  curDoneStat = 8'h02;
  logic [7:0]  curRdByte   = 8'h00;
  logic [23:0] junk        = 24'h5A3C96;
  logic [7:0]  prevData;
  logic        prevErr;
  busT         expQ[$];

  // Responder: status reads return busy for the first curBusy polls of a request, then done.
  always @(posedge clk)
    if (!pread && address == 2'd2) pollCount <= pollCount + 1;

  always_comb begin
    tbIdx    = pollCount - pollBase;
    readdata = {junk, junk[7:0]};
    if (!pread && address == 2'd2)      readdata[7:0] = (tbIdx < curBusy) ? curBusyStat : curDoneStat;
    else if (!pread && address == 2'd0) readdata[7:0] = curRdByte;
  end

  function automatic busT mk(input logic pw, input logic pr, input logic [1:0] a,
                             input logic [31:0] wd, input logic rv, input logic rdy);
    busT b;
    b.pw = pw; b.pr = pr; b.addr = a; b.wd = wd; b.rv = rv; b.rdy = rdy;
    return b;
  endfunction

  function automatic busT obsBus();
    return mk(pwrite, pread, address, writedata, rsp_valid, req_ready);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obsV, input logic [63:0] expV);
    nChecks++;
    assert (obsV === expV) nPass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obsV, expV);
  endtask

  // Issues one request and checks every bus cycle up to and including the response.
  task automatic applyStimulus(input logic [7:0] cmd, input logic hasW, input logic [7:0] wd,
                               input logic rd, input logic [7:0] rdByte, input int nBusy,
                               input logic [7:0] busyStat, input logic [7:0] doneStat);
    int         nPolls;
    logic       tOut;
    logic [7:0] expData;
    busT        e;
    tOut    = (nBusy >= MAX_POLLS);
    nPolls  = tOut ? MAX_POLLS : nBusy + 1;
    expData = tOut ? busyStat : (rd ? rdByte : doneStat);
    expQ.delete();
    if (hasW) begin
      expQ.push_back(mk(1'b0, 1'b1, 2'd0, {24'd0, wd}, 1'b0, 1'b0));
      expQ.push_back(mk(1'b1, 1'b1, 2'd0, {24'd0, wd}, 1'b0, 1'b0));
    end
    expQ.push_back(mk(1'b0, 1'b1, 2'd1, {24'd0, cmd}, 1'b0, 1'b0));
    expQ.push_back(mk(1'b1, 1'b1, 2'd1, {24'd0, cmd}, 1'b0, 1'b0));
    for (int i = 0; i < nPolls; i++) begin
      expQ.push_back(mk(1'b1, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0));
      if (i < nPolls - 1)
        for (int g = 0; g < POLL_GAP; g++) expQ.push_back(mk(1'b1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0));
    end
    if (!tOut && rd) expQ.push_back(mk(1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0));
    expQ.push_back(mk(1'b1, 1'b1, 2'd0, 32'd0, 1'b1, 1'b0));

    curBusy     = nBusy;
    curBusyStat = busyStat;
    curDoneStat = doneStat;
    curRdByte   = rdByte;
    junk        = 24'($urandom);
    pollBase    = pollCount;
    req_valid     = 1'b1;
    req_cmd       = cmd;
    req_has_wdata = hasW;
    req_wdata     = wd;
    req_rd        = rd;
    checkOutput("ready_before_accept", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid     = 1'b0;
    req_cmd       = 8'($urandom);
    req_has_wdata = 1'($urandom);
    req_wdata     = 8'($urandom);
    req_rd        = 1'($urandom);
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      e = expQ[i];
      checkOutput($sformatf("bus_cmd%02h_c%0d", cmd, i + 1), 64'(obsBus()), 64'(e));
      if (!e.rv) checkOutput($sformatf("rsp_hold_c%0d", i + 1), 64'({rsp_err, rsp_data}), 64'({prevErr, prevData}));
    end
    checkOutput("rsp_data", 64'(rsp_data), 64'(expData));
    checkOutput("rsp_err", 64'(rsp_err), 64'(tOut));
    @(negedge clk);
    checkOutput("idle_after_resp", 64'(obsBus()), 64'(mk(1'b1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1)));
    checkOutput("rsp_held_idle", 64'({rsp_err, rsp_data}), 64'({tOut, expData}));
    prevData = expData;
    prevErr  = tOut;
  endtask

  // Reset sanity, directed command scenarios, mid-poll reset, then randomized requests.
  initial begin
    logic [7:0] bs, ds;
    rst = 1'b1; req_valid = 1'b0; req_cmd = 8'd0; req_has_wdata = 1'b0;
    req_wdata = 8'd0; req_rd = 1'b0;
    prevData = 8'd0; prevErr = 1'b0;
    #1;
    checkOutput("reset_bus", 64'(obsBus()), 64'(mk(1'b1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1)));
    checkOutput("reset_rsp", 64'({rsp_err, rsp_data}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(8'h09, 1'b0, 8'h00, 1'b0, 8'h00, 0, 8'h01, 8'h02);
    applyStimulus(8'h11, 1'b1, 8'h5A, 1'b0, 8'h00, 0, 8'h01, 8'h02);
    applyStimulus(8'h07, 1'b0, 8'h00, 1'b0, 8'h00, 3, 8'h01, 8'h02);
    applyStimulus(8'h0E, 1'b0, 8'h00, 1'b1, 8'h2C, 0, 8'h01, 8'h02);
    applyStimulus(8'h07, 1'b0, 8'h00, 1'b1, 8'hEE, MAX_POLLS, 8'h01, 8'h02);
    applyStimulus(8'h0E, 1'b1, 8'hC3, 1'b1, 8'h96, 2, 8'h00, 8'hF6);

    curBusy = 100; curBusyStat = 8'h01; pollBase = pollCount;
    req_valid = 1'b1; req_cmd = 8'h07; req_has_wdata = 1'b0; req_rd = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("poll_before_reset", 64'({pread, address}), 64'({1'b0, 2'd2}));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_in_gap_bus", 64'(obsBus()), 64'(mk(1'b1, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1)));
    checkOutput("reset_in_gap_rsp", 64'({rsp_err, rsp_data}), 64'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset_hold_no_rsp", 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
    end
    rst = 1'b0;
    prevData = 8'd0; prevErr = 1'b0;
    applyStimulus(8'h09, 1'b1, 8'h11, 1'b1, 8'h77, 1, 8'h03, 8'h02);

    for (int n = 0; n < 16; n++) begin
      bs = 8'($urandom);
      if (!bs[0] && bs[1]) bs[0] = 1'b1;
      ds = {6'($urandom), 2'b10};
      applyStimulus(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                    $urandom_range(0, MAX_POLLS), bs, ds);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nand_avalon_host.md
# nand_avalon_host

Synthesizable bus initiator for the `nand_avalon` register interface. It accepts one high-level controller command at a time and performs the full host-side sequence on the register port: optional data-register write, command-register write, status polling until done, and optional data-register read. It sits between a CPU-less sequencer (BIST, boot loader) and `nand_avalon`, replacing software register banging.

## Interface
Parameters:
- `POLL_GAP`, 2: idle cycles between consecutive status polls (0 = back-to-back).
- `MAX_POLLS`, 65535: status reads allowed before the command is declared timed out (≥1).

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_cmd`  in  8  controller command code written to the command register.
- `req_has_wdata`  in  1  write `req_wdata` to the data register before the command.
- `req_wdata`  in  8  data byte for the data register.
- `req_rd`  in  1  read the data register after completion.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_data`  out  8  data-register byte if `req_rd`, else final status byte.
- `rsp_err`  out  1  poll timeout; qualified by `rsp_valid`.
- `address`  out  2  register select: 0 data, 1 command, 2 status.
- `pwrite`  out  1  active-low write strobe.
- `pread`  out  1  active-low read strobe.
- `writedata`  out  32  write data, byte zero-extended.
- `readdata`  in  32  read data from `nand_avalon`; bits [7:0] used.

## Operation
- Request fields are captured on the accept edge (`req_valid && req_ready`); inputs are ignored at all other times.
- States, one cycle each unless noted: IDLE, WD_STB, WD_HOLD, CMD_STB, CMD_HOLD, POLL, GAP (`POLL_GAP` cycles, skipped if 0), RD, RESP.
- Transitions:
  - IDLE → WD_STB on accept with `has_wdata`, otherwise → CMD_STB.
  - WD_STB → WD_HOLD → CMD_STB → CMD_HOLD → POLL.
  - POLL, status done (bit0 = 0 and bit1 = 1) → RD if `rd`, else → RESP.
  - POLL, not done: if the poll count has reached `MAX_POLLS` → RESP with error; else → GAP, then back to POLL.
  - RD → RESP → IDLE.
- Write access (the *_STB/*_HOLD pair):
  - STB cycle: `address` and `writedata` valid, `pwrite`=0.
  - HOLD cycle: `address` and `writedata` unchanged, `pwrite`=1.
  - `pread`=1 throughout.
- Read access (POLL and RD): `address` valid, `pread`=0, `pwrite`=1 for exactly one cycle. `readdata[7:0]` is registered on the clock edge that ends that cycle.
- Poll counter: width `$clog2(MAX_POLLS+1)`, cleared on accept, incremented on every POLL cycle, saturating.
- RESP: `rsp_valid`=1 for one cycle.
  - `rsp_err`=1 only on timeout.
  - On timeout the RD state is skipped and `rsp_data` is the last status byte read.
- Inactive bus values: `pwrite`=1, `pread`=1, `address`=0, `writedata`=0. These apply in IDLE, GAP, and RESP.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, bus at inactive values, state IDLE, counter 0.
- Reset mid-operation: outputs go to reset values immediately and asynchronously. No response is issued, and an access in flight is abandoned.
- Latency is counted from the accept edge as cycle 1; `POLL_GAP`=0 and the first poll succeeds:
  - No wdata, no rd: CMD_STB c1, CMD_HOLD c2, POLL c3, RESP c4.
  - wdata + rd: `rsp_valid` in c7.
- Each failed poll adds 1 + `POLL_GAP` cycles.
- `req_ready` drops the cycle after accept and returns high in the cycle after RESP. The minimum request spacing is therefore 5 cycles with no wdata and no rd.
- `rsp_data` and `rsp_err` are held from RESP until the next RESP.

## Test plan
- Reset: `rst` pulse with `nand_avalon` idle → `req_ready`=1, `pwrite`=`pread`=1, no `rsp_valid`. Then CHIP_ENABLE (cmd 9), status 0x02 → command-register write of 0x09, one poll, `rsp_valid` in cycle 4, `rsp_data`=0x02, `rsp_err`=0.
- Data write: CTRL_SET_DATA_PAGE_BYTE (cmd 17) with `has_wdata`, wdata 0x5A → data-register write of 0x0000005A, then command write of 0x11, both with exact strobe/hold waveforms. Completes without error.
- Busy polling: NAND_PAGE_PROGRAM (cmd 7) with `POLL_GAP`=2, status reading busy for 3 polls → exactly 4 status reads spaced 3 cycles apart, then `rsp_valid`.
- Read path: CTRL_GET_ID_BYTE (cmd 14) with `req_rd`, `readdata` = 0x2C → `rsp_data`=0x2C; the data-register read occurs one cycle after the successful poll.
- Timeout: `MAX_POLLS`=4, status stuck at 0x01 → 4 polls, then `rsp_err`=1, `rsp_data`=0x01, no data read, `req_ready` back high.
- Reset mid-poll: assert `rst` during GAP → bus goes inactive the same cycle and no `rsp_valid`. The next request executes normally.
